// File: rtl/mv_ctrl_pkg.sv
// rtl/mv_ctrl_pkg.sv - shared types and helpers for the matrix-vector MAC controller
// Holds the FSM state encoding, a clog2 that never returns less than 1, and the
// bit layout of one delay-pipe entry {row, last, first, valid}.
package mv_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Address/index widths must be at least one bit even for a depth of 1.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Delay-pipe entry field positions; the row index occupies the top bits.
    localparam int PE_VALID   = 0;
    localparam int PE_FIRST   = 1;
    localparam int PE_LAST    = 2;
    localparam int PE_ROW_LSB = 3;

    function automatic int pe_width(input int row_w);
        return PE_ROW_LSB + row_w;
    endfunction

endpackage

// File: rtl/ctrl_delay_pipe.sv
// rtl/ctrl_delay_pipe.sv - fixed-depth shift register with asynchronous flush
// Ports:
//   clk_i  - clock
//   rstn_i - asynchronous active-low flush of every stage
//   d_i    - entry captured each cycle
//   q_o    - entry captured DEPTH cycles earlier
module ctrl_delay_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mv_ctrl_fsm.sv
// rtl/mv_ctrl_fsm.sv - matrix-vector MAC controller sequencing NUM_ROWS dot products
// Ports:
//   clk_i, rstn_i          - clock, asynchronous active-low reset
//   start_i                - run request, only honoured in IDLE
//   stall_i                - hold off new SRAM reads while high
//   w_addr_o, w_en_o       - weight SRAM read port (row*VEC_LEN+col)
//   x_addr_o, x_en_o       - input SRAM read port (col)
//   mac_en_o/clr_o/last_o  - MAC controls aligned to SRAM read data
//   out_valid_o, out_row_o - row result pulse and its row index
//   busy_o, done_o         - sequencer handshake
module mv_ctrl_fsm
    import mv_ctrl_pkg::*;
#(
    parameter int VEC_LEN  = 8,
    parameter int NUM_ROWS = 4,
    parameter int RD_LAT   = 1,
    parameter int X_ADDR_W = clog2_min1(VEC_LEN),
    parameter int W_ADDR_W = clog2_min1(VEC_LEN * NUM_ROWS),
    parameter int ROW_W    = clog2_min1(NUM_ROWS)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                start_i,
    input  logic                stall_i,
    output logic [W_ADDR_W-1:0] w_addr_o,
    output logic                w_en_o,
    output logic [X_ADDR_W-1:0] x_addr_o,
    output logic                x_en_o,
    output logic                mac_en_o,
    output logic                mac_clr_o,
    output logic                mac_last_o,
    output logic                out_valid_o,
    output logic [ROW_W-1:0]    out_row_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int                  PE_W     = pe_width(ROW_W);
    localparam logic [X_ADDR_W-1:0] COL_LAST = X_ADDR_W'(VEC_LEN - 1);
    localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(NUM_ROWS - 1);

    state_e              state_q;
    logic [X_ADDR_W-1:0] col_q;
    logic [ROW_W-1:0]    row_q;
    logic [W_ADDR_W-1:0] w_addr_q;
    logic                busy_q;
    logic                done_q;
    logic                out_valid_q;
    logic [ROW_W-1:0]    out_row_q;

    logic                issue;
    logic                col_last;
    logic [PE_W-1:0]     pe_d;
    logic [PE_W-1:0]     pe_q;
    logic [ROW_W-1:0]    pe_row;

    assign issue    = (state_q == ST_RUN) && !stall_i;
    assign col_last = (col_q == COL_LAST);

    // Idle entries are all-zero so the MAC controls stay low outside a run.
    always_comb begin
        pe_d                        = '0;
        pe_d[PE_VALID]              = issue;
        pe_d[PE_FIRST]              = issue && (col_q == '0);
        pe_d[PE_LAST]               = issue && col_last;
        pe_d[PE_ROW_LSB +: ROW_W]   = issue ? row_q : '0;
    end

    // Tags travel alongside the SRAM reads so the MAC sees them with the data.
    ctrl_delay_pipe #(
        .DEPTH (RD_LAT),
        .WIDTH (PE_W)
    ) u_delay_pipe (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (pe_d),
        .q_o    (pe_q)
    );

    assign pe_row = pe_q[PE_ROW_LSB +: ROW_W];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            w_addr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
        end else begin
            // Result flag trails the last accumulate by one cycle; the row is held.
            out_valid_q <= mac_en_o && mac_last_o;
            if (mac_en_o && mac_last_o) begin
                out_row_q <= pe_row;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        // Running weight address avoids a row*VEC_LEN multiply.
                        w_addr_q <= w_addr_q + W_ADDR_W'(1);
                        if (col_last) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                row_q    <= '0;
                                w_addr_q <= '0;
                                state_q  <= ST_DRAIN;
                            end else begin
                                row_q <= row_q + ROW_W'(1);
                            end
                        end else begin
                            col_q <= col_q + X_ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_q && (out_row_q == ROW_LAST)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_en_o      = issue;
    assign x_en_o      = issue;
    assign w_addr_o    = w_addr_q;
    assign x_addr_o    = col_q;
    assign mac_en_o    = pe_q[PE_VALID];
    assign mac_clr_o   = pe_q[PE_FIRST] & pe_q[PE_VALID];
    assign mac_last_o  = pe_q[PE_LAST] & pe_q[PE_VALID];
    assign out_valid_o = out_valid_q;
    assign out_row_o   = out_row_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_mv_ctrl_fsm.sv
// tb/tb_mv_ctrl_fsm.sv - self-checking bench for mv_ctrl_fsm
module tb_mv_ctrl_fsm;

    localparam int MAXC = 260;
    localparam int NF   = 11;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    int   sel   = 0;

    always #5 clk = ~clk;

    logic       start_a, stall_a, start_b, stall_b;
    logic [4:0] a_w_addr;
    logic [2:0] a_x_addr;
    logic [1:0] a_orow;
    logic       a_w_en, a_x_en, a_men, a_mclr, a_mlast, a_ov, a_busy, a_done;
    logic [1:0] b_w_addr;
    logic [1:0] b_x_addr;
    logic [0:0] b_orow;
    logic       b_w_en, b_x_en, b_men, b_mclr, b_mlast, b_ov, b_busy, b_done;

    assign start_a = (sel == 0) ? start : 1'b0;
    assign stall_a = (sel == 0) ? stall : 1'b0;
    assign start_b = (sel == 1) ? start : 1'b0;
    assign stall_b = (sel == 1) ? stall : 1'b0;

    mv_ctrl_fsm u_dut_a (
        .clk_i(clk), .rstn_i(rstn), .start_i(start_a), .stall_i(stall_a),
        .w_addr_o(a_w_addr), .w_en_o(a_w_en), .x_addr_o(a_x_addr), .x_en_o(a_x_en),
        .mac_en_o(a_men), .mac_clr_o(a_mclr), .mac_last_o(a_mlast),
        .out_valid_o(a_ov), .out_row_o(a_orow), .busy_o(a_busy), .done_o(a_done)
    );

    mv_ctrl_fsm #(.VEC_LEN(4), .NUM_ROWS(1), .RD_LAT(3)) u_dut_b (
        .clk_i(clk), .rstn_i(rstn), .start_i(start_b), .stall_i(stall_b),
        .w_addr_o(b_w_addr), .w_en_o(b_w_en), .x_addr_o(b_x_addr), .x_en_o(b_x_en),
        .mac_en_o(b_men), .mac_clr_o(b_mclr), .mac_last_o(b_mlast),
        .out_valid_o(b_ov), .out_row_o(b_orow), .busy_o(b_busy), .done_o(b_done)
    );

    // Field order: w_en w_addr x_en x_addr mac_en mac_clr mac_last out_valid out_row busy done
    logic [31:0] obs [NF];
    always_comb begin
        if (sel == 0) begin
            obs[0] = {31'd0, a_w_en};  obs[1] = {27'd0, a_w_addr};
            obs[2] = {31'd0, a_x_en};  obs[3] = {29'd0, a_x_addr};
            obs[4] = {31'd0, a_men};   obs[5] = {31'd0, a_mclr};
            obs[6] = {31'd0, a_mlast}; obs[7] = {31'd0, a_ov};
            obs[8] = {30'd0, a_orow};  obs[9] = {31'd0, a_busy};
            obs[10] = {31'd0, a_done};
        end else begin
            obs[0] = {31'd0, b_w_en};  obs[1] = {30'd0, b_w_addr};
            obs[2] = {31'd0, b_x_en};  obs[3] = {30'd0, b_x_addr};
            obs[4] = {31'd0, b_men};   obs[5] = {31'd0, b_mclr};
            obs[6] = {31'd0, b_mlast}; obs[7] = {31'd0, b_ov};
            obs[8] = {31'd0, b_orow};  obs[9] = {31'd0, b_busy};
            obs[10] = {31'd0, b_done};
        end
    end

    string fname [NF] = '{"w_en", "w_addr", "x_en", "x_addr", "mac_en", "mac_clr",
                          "mac_last", "out_valid", "out_row", "busy", "done"};

    int          errors = 0;
    int          checks = 0;
    int          st_v [MAXC];
    int          sl_v [MAXC];
    int          e_tab [MAXC][NF];
    logic [31:0] o_tab [MAXC][NF];
    int          row_hold [2] = '{0, 0};

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            st_v[i] = 0;
            sl_v[i] = 0;
        end
    endtask

    // Timeline model: walks the element list of each run, placing issues on
    // non-stalled cycles and deriving MAC/result/done timing from the latencies.
    task automatic build_model(input int t, input int v, input int r, input int l, input int d);
        int n, a, s, c, k, lst, dc, rh, e;
        n = v * r;
        for (int i = 0; i < MAXC; i++)
            for (int f = 0; f < NF; f++) e_tab[i][f] = 0;
        a = 0;
        while (a < t) begin
            s = a;
            while (s < t && st_v[s] == 0) s++;
            if (s >= t) break;
            c = s + 1;
            k = 0;
            while (k < n && c < t) begin
                e_tab[c][9] = 1;
                e_tab[c][1] = k;
                e_tab[c][3] = k % v;
                if (sl_v[c] == 0) begin
                    e_tab[c][0] = 1;
                    e = c + l;
                    if (e < t) begin
                        e_tab[e][4] = 1;
                        e_tab[e][5] = (k % v == 0) ? 1 : 0;
                        e_tab[e][6] = (k % v == v - 1) ? 1 : 0;
                    end
                    if (k % v == v - 1 && e + 1 < t) begin
                        e_tab[e+1][7] = 1;
                        e_tab[e+1][8] = k / v;
                    end
                    k++;
                end
                c++;
            end
            if (k < n) break;
            lst = c - 1;
            dc  = lst + l + 2;
            for (int x = lst + 1; x < dc && x < t; x++) e_tab[x][9] = 1;
            if (dc < t) e_tab[dc][10] = 1;
            a = dc + 1;
        end
        rh = row_hold[d];
        for (int i = 0; i < t; i++) begin
            e_tab[i][2] = e_tab[i][0];
            if (e_tab[i][7] == 1) rh = e_tab[i][8];
            e_tab[i][8] = rh;
        end
        row_hold[d] = rh;
    endtask

    // Applies one cycle of stimulus per iteration and records mid-cycle outputs.
    task automatic drive_cycles(input int t);
        for (int c = 0; c < t; c++) begin
            start = (st_v[c] != 0);
            stall = (sl_v[c] != 0);
            @(negedge clk);
            for (int f = 0; f < NF; f++) o_tab[c][f] = obs[f];
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        @(negedge clk);
        for (int f = 0; f < NF; f++) begin
            checks++;
            if (obs[f] !== 32'd0) begin
                errors++;
                $display("FAIL reset_a %s: got %0d expected 0", fname[f], obs[f]);
            end
        end
        sel = 1;
        #1;
        for (int f = 0; f < NF; f++) begin
            checks++;
            if (obs[f] !== 32'd0) begin
                errors++;
                $display("FAIL reset_b %s: got %0d expected 0", fname[f], obs[f]);
            end
        end
        sel = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        int dpos, dcnt, ovc;
        sel = 0;
        clear_stim();
        st_v[0] = 1;
        build_model(40, 8, 4, 1, 0);
        drive_cycles(40);
        dpos = -1; dcnt = 0; ovc = 0;
        for (int c = 0; c < 40; c++) begin
            for (int f = 0; f < NF; f++) begin
                checks++;
                if (o_tab[c][f] !== e_tab[c][f]) begin
                    errors++;
                    $display("FAIL basic %s cycle %0d: got %0d expected %0d", fname[f], c, o_tab[c][f], e_tab[c][f]);
                end
            end
            if (o_tab[c][10] === 32'd1) begin dcnt++; if (dpos < 0) dpos = c; end
            if (o_tab[c][7] === 32'd1) ovc++;
        end
        checks++;
        if (dpos != 35 || dcnt != 1) begin
            errors++;
            $display("FAIL basic_done_cycle: got cycle %0d count %0d expected cycle 35 count 1", dpos, dcnt);
        end
        checks++;
        if (ovc != 4) begin
            errors++;
            $display("FAIL basic_out_valid_count: got %0d expected 4", ovc);
        end
    endtask

    task automatic test_stall();
        int dpos;
        sel = 0;
        clear_stim();
        st_v[0] = 1;
        for (int c = 5; c <= 7; c++) sl_v[c] = 1;
        build_model(42, 8, 4, 1, 0);
        drive_cycles(42);
        dpos = -1;
        for (int c = 0; c < 42; c++) begin
            for (int f = 0; f < NF; f++) begin
                checks++;
                if (o_tab[c][f] !== e_tab[c][f]) begin
                    errors++;
                    $display("FAIL stall %s cycle %0d: got %0d expected %0d", fname[f], c, o_tab[c][f], e_tab[c][f]);
                end
            end
            if (o_tab[c][10] === 32'd1 && dpos < 0) dpos = c;
        end
        checks++;
        if (dpos != 38) begin
            errors++;
            $display("FAIL stall_done_cycle: got %0d expected 38", dpos);
        end
        checks++;
        if (o_tab[6][1] !== 32'd4 || o_tab[6][0] !== 32'd0) begin
            errors++;
            $display("FAIL stall_hold: got addr %0d en %0d expected addr 4 en 0", o_tab[6][1], o_tab[6][0]);
        end
    endtask

    task automatic test_rd_lat3();
        int dpos, ovpos;
        sel = 1;
        clear_stim();
        st_v[0] = 1;
        build_model(14, 4, 1, 3, 1);
        drive_cycles(14);
        dpos = -1; ovpos = -1;
        for (int c = 0; c < 14; c++) begin
            for (int f = 0; f < NF; f++) begin
                checks++;
                if (o_tab[c][f] !== e_tab[c][f]) begin
                    errors++;
                    $display("FAIL rd_lat3 %s cycle %0d: got %0d expected %0d", fname[f], c, o_tab[c][f], e_tab[c][f]);
                end
            end
            if (o_tab[c][10] === 32'd1 && dpos < 0) dpos = c;
            if (o_tab[c][7] === 32'd1 && ovpos < 0) ovpos = c;
        end
        checks++;
        if (dpos != 9 || ovpos != 8) begin
            errors++;
            $display("FAIL rd_lat3_timing: got done %0d out_valid %0d expected done 9 out_valid 8", dpos, ovpos);
        end
        sel = 0;
    endtask

    task automatic test_start_during_run();
        int dcnt;
        sel = 0;
        clear_stim();
        st_v[0] = 1;
        st_v[10] = 1;
        build_model(40, 8, 4, 1, 0);
        drive_cycles(40);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            for (int f = 0; f < NF; f++) begin
                checks++;
                if (o_tab[c][f] !== e_tab[c][f]) begin
                    errors++;
                    $display("FAIL start_in_run %s cycle %0d: got %0d expected %0d", fname[f], c, o_tab[c][f], e_tab[c][f]);
                end
            end
            if (o_tab[c][10] === 32'd1) dcnt++;
        end
        checks++;
        if (dcnt != 1) begin
            errors++;
            $display("FAIL start_in_run_done_count: got %0d expected 1", dcnt);
        end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        sel = 0;
        clear_stim();
        for (int c = 0; c < 100; c++) st_v[c] = 1;
        build_model(112, 8, 4, 1, 0);
        drive_cycles(112);
        for (int c = 0; c < 112; c++) begin
            for (int f = 0; f < NF; f++) begin
                checks++;
                if (o_tab[c][f] !== e_tab[c][f]) begin
                    errors++;
                    $display("FAIL back_to_back %s cycle %0d: got %0d expected %0d", fname[f], c, o_tab[c][f], e_tab[c][f]);
                end
            end
            if (o_tab[c][10] === 32'd1) dq.push_back(c);
        end
        checks++;
        if (dq.size() != 3 || dq[0] != 35 || dq[1] != 71 || dq[2] != 107) begin
            errors++;
            $display("FAIL back_to_back_done: got %0d pulses first %0d expected 3 pulses at 35,71,107",
                     dq.size(), (dq.size() > 0) ? dq[0] : -1);
        end
    endtask

    task automatic test_random_stall();
        int t, v, r, l;
        for (int it = 0; it < 4; it++) begin
            sel = it % 2;
            if (sel == 0) begin t = 250; v = 8; r = 4; l = 1; end
            else begin t = 100; v = 4; r = 1; l = 3; end
            clear_stim();
            st_v[0] = 1;
            for (int c = 1; c <= 20; c++) st_v[c] = ($urandom_range(0, 7) == 0) ? 1 : 0;
            for (int c = 0; c < t; c++) sl_v[c] = ($urandom_range(0, 3) == 0) ? 1 : 0;
            build_model(t, v, r, l, sel);
            drive_cycles(t);
            for (int c = 0; c < t; c++) begin
                for (int f = 0; f < NF; f++) begin
                    checks++;
                    if (o_tab[c][f] !== e_tab[c][f]) begin
                        errors++;
                        $display("FAIL random_stall it%0d %s cycle %0d: got %0d expected %0d", it, fname[f], c, o_tab[c][f], e_tab[c][f]);
                    end
                end
            end
        end
        sel = 0;
    endtask

    task automatic test_reset_mid_run();
        int dcnt;
        sel = 0;
        clear_stim();
        st_v[0] = 1;
        build_model(15, 8, 4, 1, 0);
        drive_cycles(15);
        dcnt = 0;
        for (int c = 0; c < 15; c++) begin
            for (int f = 0; f < NF; f++) begin
                checks++;
                if (o_tab[c][f] !== e_tab[c][f]) begin
                    errors++;
                    $display("FAIL reset_mid_run %s cycle %0d: got %0d expected %0d", fname[f], c, o_tab[c][f], e_tab[c][f]);
                end
            end
        end
        rstn = 1'b0;
        #1;
        for (int f = 0; f < NF; f++) begin
            checks++;
            if (obs[f] !== 32'd0) begin
                errors++;
                $display("FAIL reset_mid_run_clear %s: got %0d expected 0", fname[f], obs[f]);
            end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (obs[10] !== 32'd0) dcnt++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (dcnt != 0) begin
            errors++;
            $display("FAIL reset_mid_run_no_done: got %0d pulses expected 0", dcnt);
        end
        row_hold[0] = 0;
        row_hold[1] = 0;
        rstn = 1'b1;
        test_basic();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_rd_lat3();
        test_start_during_run();
        test_back_to_back();
        test_random_stall();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
